operand_stack: RTL and testbench
================================

# operand_stack

LIFO operand stack feeding the stack-machine CPU datapath. Consumes the controller's `push`, `pop` and `data_to_push` strobes and returns the top of stack as `data_from_stack`. Also exposes the second element so two-operand ALU ops can see both operands. Holds occupancy, full/empty status and sticky overflow/underflow error flags, all on the single CPU clock.

## Interface
- `WIDTH`, default 8: data word width, matches the CPU value bus.
- `DEPTH`, default 16: maximum number of stored words, ≥ 2.
- `CW`, default $clog2(DEPTH+1): width of `count`, derived, not overridden.

Ports:
- `clk` input 1: CPU clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `push` input 1: push `data_to_push` this cycle.
- `pop` input 1: remove the top element this cycle.
- `data_to_push` input WIDTH: word written on push.
- `clr_err` input 1: clears `overflow` and `underflow`.
- `data_from_stack` output WIDTH: current top of stack, registered, 0 when empty.
- `data_second` output WIDTH: element below top, 0 when `count` < 2.
- `count` output CW: number of stored elements, 0..DEPTH.
- `empty` output 1: `count` == 0.
- `full` output 1: `count` == DEPTH.
- `overflow` output 1: sticky, push attempted while full without a pop.
- `underflow` output 1: sticky, pop attempted while empty.

## Operation
- Storage: top-of-stack register `tos_q` plus a DEPTH-1 entry array for the lower elements, indexed by `count`-2 for the second element.
- Push only, not full: the old top moves into the array at index `count`-1, `tos_q` ← `data_to_push`, `count`+1.
- Push only, full: no state change except `overflow` ← 1.
- Pop only, not empty: `tos_q` ← array[`count`-2], or 0 if `count` == 1. `count`-1.
  - The popped value is the `data_from_stack` visible before the edge; the controller samples it in the same cycle it asserts `pop`.
- Pop only, empty: no state change except `underflow` ← 1.
- Push and pop together, not empty: replace the top. `tos_q` ← `data_to_push`, `count` unchanged, array untouched. This is legal when full.
- Push and pop together, empty: the pop is in error, `underflow` ← 1, and the push is performed, giving `count` = 1.
- Neither asserted: hold.
- Error flags stay set until `clr_err` or `reset`. If `clr_err` arrives in the same cycle as a new error, the new error wins and the flag stays 1.
- Widths: `count` never wraps. It saturates logically because illegal operations are suppressed, not clamped afterwards.

## Timing
- Reset, synchronous, checked before everything else:
  - `count` = 0, `data_from_stack` = 0, `data_second` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `underflow` = 0.
  - Array contents are don't-care.
  - A push or pop in the same cycle as reset is discarded. Reset mid-sequence empties the stack in one cycle.
- Latency 1 cycle: outputs reflect an operation after the rising edge on which it is sampled.
  - Back-to-back push/pop every cycle is supported with no bubbles.
- `data_from_stack`, `count`, `empty`, `full` and the flags are registered or simple decodes of registers.
  - `data_second` is a combinational array read at a registered index, with no input-to-output combinational path.
- No handshake: the caller must honour `full`/`empty`. Violations are only flagged, never stall.

## Structure
- Shared package `stack_pkg`: `WIDTH` default and an op encoding `STK_NOP`, `STK_PUSH`, `STK_POP`, `STK_REPL` derived from {push, pop}. The CPU controller and the bench use the same encoding.
- One sub-module, `stack_mem`: a (DEPTH-1)×WIDTH array with synchronous write and asynchronous read on two ports, the write port plus the read index for `data_second` and the pop refill. The same read index serves both because both read entry `count`-2.
- Top level `operand_stack`: `tos_q`, `count`, flags and the op decode.

## Test plan
- Reset then push 0x11, 0x22, 0x33 → `data_from_stack`=0x33, `data_second`=0x22, `count`=3; pop ×3 yields 0x33, 0x22, 0x11, then `empty`=1 and `data_from_stack`=0.
- DEPTH=16: push 16 words 0x00..0x0F → `full`=1. A 17th push of 0xAA → `overflow`=1, top still 0x0F, `count`=16.
- Pop on empty → `underflow`=1, `count`=0. Then `clr_err` → flags 0. `clr_err` together with another empty pop → `underflow` stays 1.
- Stack {0x05, 0x07}, push+pop with 0x0C → top 0x0C, `data_second`=0x05, `count`=2. Same op when full → replace, `overflow` stays 0.
- Push+pop on empty with 0x44 → `underflow`=1, `count`=1, top 0x44.
- Push 5 words, then assert `reset` with `push`=1 → next cycle `count`=0, `empty`=1, top 0, flags 0.

Source files
------------

// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the operand stack and its users (CPU controller,
// testbench): default data width and the operation encoding derived from the
// {push, pop} strobe pair.
// -----------------------------------------------------------------------------
package stack_pkg;

    // Default data word width, matches the CPU value bus.
    localparam int STK_WIDTH_DEF = 8;

    // Operation encoding, bit 1 = push, bit 0 = pop.
    typedef enum logic [1:0] {
        STK_NOP  = 2'b00,
        STK_POP  = 2'b01,
        STK_PUSH = 2'b10,
        STK_REPL = 2'b11
    } stk_op_e;

    // Map the raw controller strobes onto the operation encoding.
    function automatic stk_op_e stk_decode(input logic push, input logic pop);
        return stk_op_e'({push, pop});
    endfunction

endpackage : stack_pkg

// File: rtl/stack_mem.sv
// -----------------------------------------------------------------------------
// stack_mem
// Storage for the stack elements below the top of stack.
// ENTRIES x WIDTH array, synchronous write, asynchronous read.
//
// Ports:
//   clk      - clock, write on rising edge
//   i_we     - write enable
//   i_waddr  - write index
//   i_wdata  - write data
//   i_raddr  - read index (second element / pop refill)
//   o_rdata  - read data, 0 when the index is outside the array
// -----------------------------------------------------------------------------
module stack_mem
    import stack_pkg::*;
#(
    parameter int WIDTH   = STK_WIDTH_DEF,
    parameter int ENTRIES = 15,
    parameter int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [ENTRIES];

    // Synchronous write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read port, guarded so an unused index never reads X.
    always_comb begin
        o_rdata = {WIDTH{1'b0}};
        if (int'(i_raddr) < ENTRIES) begin
            o_rdata = r_mem[i_raddr];
        end else begin
            o_rdata = {WIDTH{1'b0}};
        end
    end

endmodule : stack_mem

// File: rtl/operand_stack.sv
// -----------------------------------------------------------------------------
// operand_stack
// LIFO operand stack for the stack-machine CPU datapath. The top element is
// held in a register, the remaining DEPTH-1 elements in stack_mem.
//
// Ports:
//   clk             - CPU clock
//   reset           - synchronous active-high reset
//   push / pop      - operation strobes (both = replace top)
//   data_to_push    - word written on push / replace
//   clr_err         - clears the sticky error flags
//   data_from_stack - registered top of stack, 0 when empty
//   data_second     - element below top, 0 when count < 2
//   count           - number of stored elements, 0..DEPTH
//   empty / full    - occupancy status
//   overflow        - sticky: push while full without pop
//   underflow       - sticky: pop while empty
// -----------------------------------------------------------------------------
module operand_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = STK_WIDTH_DEF,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            data_to_push,
    input  logic                        clr_err,
    output logic [WIDTH-1:0]            data_from_stack,
    output logic [WIDTH-1:0]            data_second,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        empty,
    output logic                        full,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int CW      = $clog2(DEPTH + 1);
    localparam int ENTRIES = DEPTH - 1;
    localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Registered state
    logic [WIDTH-1:0] r_tos;
    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_ovf;
    logic             r_unf;

    // Next-state and datapath wires
    stk_op_e          w_op;
    logic [WIDTH-1:0] w_tos_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_mem_rdata;
    logic [WIDTH-1:0] w_second;

    // Lower elements: old top is written at count-1, second element read at
    // count-2. Both indices derive only from the count register.
    assign w_waddr = AW'(r_count - CW'(1));
    assign w_raddr = AW'(r_count - CW'(2));

    stack_mem #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (r_tos),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_rdata)
    );

    // Second element view; doubles as the refill value for a pop, which is
    // 0 when only one element remains.
    always_comb begin
        w_second = {WIDTH{1'b0}};
        if (r_count >= CW'(2)) begin
            w_second = w_mem_rdata;
        end else begin
            w_second = {WIDTH{1'b0}};
        end
    end

    // Operation decode and next-state computation. Illegal operations are
    // suppressed here so count can never leave 0..DEPTH.
    always_comb begin
        w_op        = stk_decode(push, pop);
        w_tos_nxt   = r_tos;
        w_count_nxt = r_count;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        w_we        = 1'b0;
        case (w_op)
            STK_PUSH: begin
                if (r_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    // An empty stack has no old top worth storing.
                    w_we        = !r_empty && !reset;
                    w_tos_nxt   = data_to_push;
                    w_count_nxt = r_count + CW'(1);
                end
            end
            STK_POP: begin
                if (r_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_tos_nxt   = w_second;
                    w_count_nxt = r_count - CW'(1);
                end
            end
            STK_REPL: begin
                // On empty the pop half errors but the push half still lands.
                if (r_empty) begin
                    w_unf_set   = 1'b1;
                    w_tos_nxt   = data_to_push;
                    w_count_nxt = CW'(1);
                end else begin
                    w_tos_nxt   = data_to_push;
                end
            end
            default: begin
                w_tos_nxt   = r_tos;
                w_count_nxt = r_count;
            end
        endcase
    end

    // State registers; reset has priority and discards any concurrent op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tos   <= {WIDTH{1'b0}};
            r_count <= {CW{1'b0}};
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_tos   <= w_tos_nxt;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == {CW{1'b0}});
            r_full  <= (w_count_nxt == CW'(DEPTH));
            // A new error beats a simultaneous clear.
            r_ovf   <= w_ovf_set | (r_ovf & ~clr_err);
            r_unf   <= w_unf_set | (r_unf & ~clr_err);
        end
    end

    assign data_from_stack = r_tos;
    assign data_second     = w_second;
    assign count           = r_count;
    assign empty           = r_empty;
    assign full            = r_full;
    assign overflow        = r_ovf;
    assign underflow       = r_unf;

endmodule : operand_stack

// File: tb/tb_operand_stack.sv
// -----------------------------------------------------------------------------
// tb_operand_stack
// Directed steps followed by random traffic, each cycle compared against a
// queue-based reference model of a LIFO with sticky error flags.
// -----------------------------------------------------------------------------
module tb_operand_stack;
    import stack_pkg::*;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          reset;
    logic          push;
    logic          pop;
    logic [W-1:0]  data_to_push;
    logic          clr_err;
    logic [W-1:0]  data_from_stack;
    logic [W-1:0]  data_second;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: back of the queue is the top of stack.
    logic [W-1:0] mq[$];
    bit           m_ovf;
    bit           m_unf;

    operand_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk             (clk),
        .reset           (reset),
        .push            (push),
        .pop             (pop),
        .data_to_push    (data_to_push),
        .clr_err         (clr_err),
        .data_from_stack (data_from_stack),
        .data_second     (data_second),
        .count           (count),
        .empty           (empty),
        .full            (full),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit p, input bit o, input logic [W-1:0] d,
                              input bit c, input bit r);
        bit ovf_set;
        bit unf_set;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && o) begin
                if (mq.size() == 0) begin
                    unf_set = 1'b1;
                    mq.push_back(d);
                end else begin
                    mq[mq.size()-1] = d;
                end
            end else if (p) begin
                if (mq.size() == D) ovf_set = 1'b1;
                else mq.push_back(d);
            end else if (o) begin
                if (mq.size() == 0) unf_set = 1'b1;
                else void'(mq.pop_back());
            end
            m_ovf = ovf_set || (m_ovf && !c);
            m_unf = unf_set || (m_unf && !c);
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] e_top;
        logic [W-1:0] e_sec;
        int n;
        n     = mq.size();
        e_top = (n >= 1) ? mq[n-1] : 8'h00;
        e_sec = (n >= 2) ? mq[n-2] : 8'h00;
        chk({tag, ".top"},   32'(data_from_stack), 32'(e_top));
        chk({tag, ".second"}, 32'(data_second),    32'(e_sec));
        chk({tag, ".count"}, 32'(count),           32'(n));
        chk({tag, ".empty"}, 32'(empty),           32'(n == 0));
        chk({tag, ".full"},  32'(full),            32'(n == D));
        chk({tag, ".ovf"},   32'(overflow),        32'(m_ovf));
        chk({tag, ".unf"},   32'(underflow),       32'(m_unf));
    endtask

    task automatic cyc(input string tag, input bit p, input bit o,
                       input logic [W-1:0] d, input bit c, input bit r);
        push         = p;
        pop          = o;
        data_to_push = d;
        clr_err      = c;
        reset        = r;
        @(posedge clk);
        model_step(p, o, d, c, r);
        #1;
        check_all(tag);
    endtask

    initial begin
        push = 1'b0; pop = 1'b0; data_to_push = 8'h00; clr_err = 1'b0; reset = 1'b1;
        m_ovf = 1'b0; m_unf = 1'b0;

        // Reset state
        cyc("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("reset.empty_const", 32'(empty), 32'd1);

        // Push three, pop three
        cyc("push11", 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        cyc("push22", 1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        cyc("push33", 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        chk("tp1.top",    32'(data_from_stack), 32'h33);
        chk("tp1.second", 32'(data_second),     32'h22);
        chk("tp1.count",  32'(count),           32'd3);
        chk("tp1.pop_val0", 32'(data_from_stack), 32'h33);
        cyc("pop0", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("tp1.pop_val1", 32'(data_from_stack), 32'h22);
        cyc("pop1", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("tp1.pop_val2", 32'(data_from_stack), 32'h11);
        cyc("pop2", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("tp1.empty", 32'(empty), 32'd1);
        chk("tp1.top0",  32'(data_from_stack), 32'h00);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < D; i++) cyc("fill", 1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        chk("tp2.full", 32'(full), 32'd1);
        cyc("push_full", 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        chk("tp2.ovf",   32'(overflow),        32'd1);
        chk("tp2.top",   32'(data_from_stack), 32'h0F);
        chk("tp2.count", 32'(count),           32'd16);
        // Replace while full: legal, no overflow
        cyc("clr_full", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc("repl_full", 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        chk("tp4.full_ovf", 32'(overflow), 32'd0);
        chk("tp4.full_top", 32'(data_from_stack), 32'h5A);

        // Underflow, clear, clear-vs-new-error
        cyc("reset2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc("pop_empty", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("tp3.unf", 32'(underflow), 32'd1);
        cyc("clr", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("tp3.unf_clr", 32'(underflow), 32'd0);
        cyc("pop_empty_clr", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        chk("tp3.unf_wins", 32'(underflow), 32'd1);

        // Replace with two elements
        cyc("clr2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc("push05", 1'b1, 1'b0, 8'h05, 1'b0, 1'b0);
        cyc("push07", 1'b1, 1'b0, 8'h07, 1'b0, 1'b0);
        cyc("repl0C", 1'b1, 1'b1, 8'h0C, 1'b0, 1'b0);
        chk("tp4.top",    32'(data_from_stack), 32'h0C);
        chk("tp4.second", 32'(data_second),     32'h05);
        chk("tp4.count",  32'(count),           32'd2);

        // Push+pop on empty
        cyc("reset3", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc("repl_empty", 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        chk("tp5.unf",   32'(underflow),       32'd1);
        chk("tp5.count", 32'(count),           32'd1);
        chk("tp5.top",   32'(data_from_stack), 32'h44);

        // Reset mid-sequence with push asserted
        for (int i = 0; i < 5; i++) cyc("push5", 1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
        cyc("reset_push", 1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
        chk("tp6.count", 32'(count),           32'd0);
        chk("tp6.empty", 32'(empty),           32'd1);
        chk("tp6.top",   32'(data_from_stack), 32'h00);
        chk("tp6.unf",   32'(underflow),       32'd0);

        // Random traffic: push-heavy, then pop-heavy, to reach both limits
        for (int i = 0; i < 600; i++) begin
            bit p;
            bit o;
            bit c;
            bit r;
            if (i < 300) begin
                p = ($urandom_range(0, 99) < 70);
                o = ($urandom_range(0, 99) < 30);
            end else begin
                p = ($urandom_range(0, 99) < 30);
                o = ($urandom_range(0, 99) < 70);
            end
            c = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 99) == 0);
            cyc("rand", p, o, 8'($urandom), c, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_operand_stack
